// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// id_width() gives the requester ID width, never narrower than one bit.
package adder_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RESP
  } arb_state_t;

  localparam logic [15:0] OPS_MAX = 16'hFFFF;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above ptr,
// otherwise wraps to the lowest set request overall.
module rr_pick
  import adder_share_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] sel;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (ID_W'(i) >= ptr);
    end
    masked = req & mask;
    // The masked half wins whenever it has a candidate; otherwise wrap around.
    sel = (|masked) ? masked : req;
    gnt_onehot = '0;
    gnt_id     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt_onehot    = '0;
        gnt_onehot[i] = 1'b1;
        gnt_id        = ID_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that serialises operand pairs from N_REQ requesters
// through one registered adder and returns ID-tagged sums on one response port.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH:0]              rsp_sum,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        busy,
  output logic [15:0]                 ops_done
);

  // Handshake: a transfer happens on a rising edge where valid and ready
  // are both high; valid holds with stable data until then, and ready is
  // only ever offered to the single round-robin winner while idle.

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [WIDTH-1:0] a_q, b_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH:0]   sum_q;

  logic [N_REQ-1:0] gnt_onehot;
  logic [ID_W-1:0]  gnt_id;
  logic             any_req;
  logic             accept;
  logic             rsp_fire;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (any_req)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = gnt_onehot;
          accept    = 1'b1;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      sum_q    <= '0;
      ops_done <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= req_a[gnt_id];
        b_q  <= req_b[gnt_id];
        id_q <= gnt_id;
      end
      // Zero-extend both operands so the carry lands in the top bit.
      if (state_q == ST_CALC) begin
        sum_q <= {1'b0, a_q} + {1'b0, b_q};
      end
      if (rsp_fire) begin
        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        if (ops_done != OPS_MAX) begin
          ops_done <= ops_done + 16'd1;
        end
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: a vector table of single transactions
// plus hand-written fairness, back-pressure and mid-operation reset sequences.
module tb_adder_share_arb;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                        clk;
  logic                        rst;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            req_ready;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [WIDTH:0]              rsp_sum;
  logic [ID_W-1:0]             rsp_id;
  logic                        busy;
  logic [15:0]                 ops_done;

  adder_share_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0]            valid;
    logic [N_REQ-1:0][WIDTH-1:0] a;
    logic [N_REQ-1:0][WIDTH-1:0] b;
    logic [ID_W-1:0]             exp_id;
    logic [WIDTH:0]              exp_sum;
    int                          stall;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  // expected response queue for the fairness run
  logic [WIDTH+ID_W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0;
  endtask

  // Starts just after a rising edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    req_a = v.a;
    req_b = v.b;
    req_valid = v.valid;
    @(negedge clk);
    check("grant_onehot", 32'(req_ready), 32'(4'b0001 << v.exp_id));
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("calc_ready", 32'(req_ready), 32'd0);
    check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    for (int k = 0; k <= v.stall; k++) begin
      #1;
      rsp_ready = (k == v.stall);
      req_valid = (k == v.stall) ? '0 : v.valid;
      @(negedge clk);
      check("resp_valid", 32'(rsp_valid), 32'd1);
      check("resp_sum", 32'(rsp_sum), 32'(v.exp_sum));
      check("resp_id", 32'(rsp_id), 32'(v.exp_id));
      check("resp_no_grant", 32'(req_ready), 32'd0);
      @(posedge clk);
    end
    #1 rsp_ready = 1'b0;
    n_done++;
    @(negedge clk);
    check("ops_done", 32'(ops_done), 32'(n_done));
    check("post_busy", 32'(busy), 32'd0);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    int seen;
    int last_cyc;
    int cyc;
    logic [WIDTH+ID_W:0] exp_e;

    vecs[0]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd100}, {8'd0, 8'd0, 8'd0, 8'd55}, 2'd0, 9'd155, 0};
    vecs[1]  = '{4'b0100, {8'd0, 8'hFF, 8'd0, 8'd0}, {8'd0, 8'h01, 8'd0, 8'd0}, 2'd2, 9'h100, 0};
    vecs[2]  = '{4'b0101, {8'd0, 8'h10, 8'd0, 8'h20}, {8'd0, 8'h01, 8'd0, 8'h02}, 2'd0, 9'h022, 5};
    vecs[3]  = '{4'b0101, {8'd0, 8'h10, 8'd0, 8'h20}, {8'd0, 8'h01, 8'd0, 8'h02}, 2'd2, 9'h011, 0};
    vecs[4]  = '{4'b1111, {8'h80, 8'h40, 8'h20, 8'h10}, {8'h80, 8'h04, 8'h02, 8'h01}, 2'd3, 9'h100, 0};
    vecs[5]  = '{4'b1111, {8'h80, 8'h40, 8'h20, 8'h10}, {8'h80, 8'h04, 8'h02, 8'h01}, 2'd0, 9'h011, 0};
    vecs[6]  = '{4'b1111, {8'h80, 8'h40, 8'h20, 8'h10}, {8'h80, 8'h04, 8'h02, 8'h01}, 2'd1, 9'h022, 2};
    vecs[7]  = '{4'b1111, {8'h80, 8'h40, 8'h20, 8'h10}, {8'h80, 8'h04, 8'h02, 8'h01}, 2'd2, 9'h044, 0};
    vecs[8]  = '{4'b1111, {8'h80, 8'h40, 8'h20, 8'h10}, {8'h80, 8'h04, 8'h02, 8'h01}, 2'd3, 9'h100, 0};
    vecs[9]  = '{4'b1000, {8'hAA, 8'd0, 8'd0, 8'd0}, {8'h55, 8'd0, 8'd0, 8'd0}, 2'd3, 9'h0FF, 0};
    vecs[10] = '{4'b0010, {8'd0, 8'd0, 8'd200, 8'd0}, {8'd0, 8'd0, 8'd100, 8'd0}, 2'd1, 9'd300, 0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // idle with no requests stays idle
    repeat (2) begin
      @(negedge clk);
      check("idle_no_req_ready", 32'(req_ready), 32'd0);
      check("idle_no_req_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;

    // all valids held high: ids rotate 0,1,2,3,0 with one response every 3 cycles
    req_a = {8'h04, 8'h03, 8'h02, 8'h01};
    req_b = {8'h40, 8'h30, 8'h20, 8'h10};
    exp_q.push_back({2'd0, 9'h011});
    exp_q.push_back({2'd1, 9'h022});
    exp_q.push_back({2'd2, 9'h033});
    exp_q.push_back({2'd3, 9'h044});
    exp_q.push_back({2'd0, 9'h011});
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    seen = 0;
    last_cyc = 0;
    cyc = 0;
    while (seen < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        exp_e = exp_q.pop_front();
        check("rr_id", 32'(rsp_id), 32'(exp_e[WIDTH+ID_W:WIDTH+1]));
        check("rr_sum", 32'(rsp_sum), 32'(exp_e[WIDTH:0]));
        if (seen > 0) check("rr_interval", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        seen++;
        if (seen == 5) req_valid = '0;
      end
    end
    check("rr_count", 32'(seen), 32'd5);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rr_ops_done", 32'(ops_done), 32'd5);
    check("rr_idle", 32'(busy), 32'd0);

    @(posedge clk);
    #1 pulse_reset();

    foreach (vecs[i]) run_txn(vecs[i]);

    // reset while the transaction is in CALC discards it
    req_a = {8'd0, 8'd0, 8'd0, 8'd100};
    req_b = {8'd0, 8'd0, 8'd0, 8'd55};
    req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ops_done", 32'(ops_done), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    n_done = 0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("discarded_rsp", 32'(seen), 32'd0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one registered WIDTH-bit adder among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, computes the full-width sum, and returns it tagged with the requester ID on a single valid/ready response port. It sits between the section-3 testbench-style producers and the adder datapath, and serialises all add operations through one resource.

## Interface
- N_REQ, 4, number of requesters; legal values are 1..16
- WIDTH, 8, operand width in bits
- ID_W, $clog2(N_REQ) (minimum 1), requester ID width; derived localparam, not overridable
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester operand valid
- req_a  input  N_REQ×WIDTH  packed array, operand A per requester
- req_b  input  N_REQ×WIDTH  packed array, operand B per requester
- req_ready  output  N_REQ  one-hot accept strobe; combinational from the state and rr_ptr registers plus req_valid
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_sum  output  WIDTH+1  registered sum, carry included
- rsp_id  output  ID_W  index of the requester that produced rsp_sum
- busy  output  1  high in every state except IDLE
- ops_done  output  16  count of completed responses; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE.** If any req_valid bit is set, pick the first set bit scanning upward from rr_ptr, wrapping from N_REQ-1 to 0.
  - Assert req_ready for the winner only, in that same cycle.
  - Capture a_q, b_q and id_q from the winner. Go to CALC.
  - If no req_valid bit is set, stay in IDLE and keep req_ready all 0.
- **CALC.** Register sum_q <= {1'b0,a_q} + {1'b0,b_q} and go to RESP. Overflow is never lost: 8'hFF + 8'h01 = 9'h100.
- **RESP.** Hold rsp_valid=1, and keep rsp_sum and rsp_id stable, until rsp_ready=1. On the handshake cycle:
  - Set rr_ptr <= (id_q == N_REQ-1) ? 0 : id_q+1.
  - Increment ops_done unless it is saturated.
  - Go to IDLE.
- req_ready is always 0 outside IDLE. Requesters hold valid and operands until they see ready. A valid that drops before grant is never serviced.
- A winner is granted at most once per transaction. The requester just served has the lowest priority on the next arbitration.
- N_REQ=1: rr_ptr stays 0 and rsp_id is always 0.
- **Reset values:**
  - state=IDLE, rr_ptr=0, req_ready=0.
  - rsp_valid=0, rsp_sum=0, rsp_id=0.
  - busy=0, ops_done=0.
  - a_q, b_q and id_q are all 0.
- **Reset asserted mid-operation** (CALC or RESP): the transaction is discarded with no response, and all registers return to their reset values immediately.

## Timing
- Accept to rsp_valid is 2 cycles. Grant happens in cycle T (IDLE). CALC is cycle T+1. rsp_valid is first high in T+2.
- If rsp_ready is held high, the minimum issue interval is 3 cycles: IDLE, CALC, RESP.
- Back-pressure: each cycle with rsp_ready=0 in RESP extends the transaction by 1 cycle. Response data does not change while stalled.
- ops_done updates on the clock edge that ends the RESP handshake cycle, so it is visible one cycle after the handshake.
- Simultaneous valids in IDLE: exactly one grant, chosen strictly by the rr_ptr rotation.

## Structure
- Package adder_share_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_RESP} arb_state_t
  - localparam OPS_MAX = 16'hFFFF
- Sub-module rr_pick, purely combinational:
  - Parameter N_REQ.
  - Inputs req[N_REQ], ptr[ID_W].
  - Outputs gnt_onehot[N_REQ], gnt_id[ID_W], any.
  - Masked/unmasked double-priority implementation.
- The add is inline and registered in CALC. No separate adder instance.

## Test plan
- Single request: after reset, req_valid=4'b0001, a=100, b=55, rsp_ready=1 → req_ready[0] high for 1 cycle; rsp_valid 2 cycles later with rsp_sum=155, rsp_id=0; ops_done=1.
- Overflow: requester 2 presents a=8'hFF, b=8'h01 → rsp_sum=9'h100, rsp_id=2.
- Round-robin fairness: all four valids held high, rsp_ready=1 → rsp_id sequence 0,1,2,3,0, with one response every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid stays high with rsp_sum/rsp_id unchanged; req_ready stays 0; no new grant until the handshake.
- Wrap and skip: rr_ptr=3 (after serving requester 2), valids 4'b0101 → grant goes to requester 0, then 2.
- Reset in CALC: rst pulsed for 1 cycle → rsp_valid never asserts for that request; busy=0 and ops_done=0 immediately; a subsequent request behaves as in the first scenario.
